// File: rtl/card_match_judge.sv
// Round controller for the card-matching game: requests deals, times the keypad
// answer, judges it against the latched cards and keeps per-player scores.
module card_match_judge #(
  parameter int NUM_PLAYERS = 2,
  parameter int COLOR_W     = 2,
  parameter int NUM_W       = 3,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int TIMEOUT     = 50000000,
  parameter int SHOW_CYCLES = 25000000,
  parameter int PENALTY     = 1,
  localparam int TW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int CW = COLOR_W + NUM_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           new_game,
  input  logic [NUM_PLAYERS*CW-1:0]      cards_in,
  input  logic                           cards_valid,
  input  logic [3:0]                     key_code,
  input  logic                           key_valid,
  output logic                           deal_req,
  output logic [TW-1:0]                  turn,
  output logic                           right,
  output logic                           wrong,
  output logic                           timeout,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           game_over,
  output logic [TW-1:0]                  winner
);

  // One timer serves both the answer window and the verdict display.
  localparam int MAX_T = (TIMEOUT > SHOW_CYCLES) ? TIMEOUT : SHOW_CYCLES;
  localparam int TMR_W = $clog2(MAX_T);

  localparam logic [TMR_W-1:0]   TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   SHOW_LAST    = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN          = SCORE_W'(WIN_SCORE);
  localparam logic [TW-1:0]      LAST_PLAYER  = TW'(NUM_PLAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAL,
    S_WAIT_KEY,
    S_SHOW,
    S_OVER
  } state_e;

  state_e                                state_q, state_d;
  logic [TMR_W-1:0]                      timer_q, timer_d;
  logic [TW-1:0]                         turn_q, turn_d;
  logic [TW-1:0]                         winner_q, winner_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   scores_q, scores_d;
  logic [CW-1:0]                         card_a_q, card_a_d;
  logic [CW-1:0]                         card_b_q, card_b_d;
  logic                                  deal_req_q, deal_req_d;
  logic                                  right_q, right_d;
  logic                                  wrong_q, wrong_d;
  logic                                  timeout_q, timeout_d;
  logic                                  game_over_q, game_over_d;

  logic [NUM_PLAYERS-1:0][CW-1:0] cards_arr;
  logic [TW-1:0]                  next_turn;
  logic                           colour_eq, number_eq, key_ok;
  logic [3:0]                     correct_code;
  logic [SCORE_W-1:0]             score_cur, score_inc, score_dec;

  assign cards_arr = cards_in;
  assign next_turn = (turn_q == LAST_PLAYER) ? '0 : turn_q + 1'b1;
  assign colour_eq = card_a_q[CW-1 -: COLOR_W] == card_b_q[CW-1 -: COLOR_W];
  assign number_eq = card_a_q[NUM_W-1:0] == card_b_q[NUM_W-1:0];
  assign key_ok    = key_valid && (key_code != 4'd0) && (key_code <= 4'd4);

  assign correct_code = (colour_eq && number_eq) ? 4'd3 :
                        colour_eq                ? 4'd1 :
                        number_eq                ? 4'd2 : 4'd4;

  assign score_cur = scores_q[turn_q];
  assign score_inc = (score_cur >= WIN) ? WIN : score_cur + 1'b1;
  assign score_dec = ((PENALTY != 0) && (score_cur != '0)) ? score_cur - 1'b1 : score_cur;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    timer_d     = timer_q;
    turn_d      = turn_q;
    winner_d    = winner_q;
    scores_d    = scores_q;
    card_a_d    = card_a_q;
    card_b_d    = card_b_q;
    deal_req_d  = 1'b0;
    right_d     = right_q;
    wrong_d     = wrong_q;
    timeout_d   = timeout_q;
    game_over_d = game_over_q;

    unique case (state_q)
      S_IDLE: ;
      S_DEAL: begin
        if (cards_valid) begin
          card_a_d = cards_arr[turn_q];
          card_b_d = cards_arr[next_turn];
          timer_d  = '0;
          state_d  = S_WAIT_KEY;
        end
      end
      S_WAIT_KEY: begin
        // A legal key on the expiry cycle takes priority over the timeout.
        if (key_ok) begin
          timer_d = '0;
          state_d = S_SHOW;
          if (key_code == correct_code) begin
            right_d          = 1'b1;
            scores_d[turn_q] = score_inc;
          end else begin
            wrong_d          = 1'b1;
            scores_d[turn_q] = score_dec;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d          = '0;
          state_d          = S_SHOW;
          timeout_d        = 1'b1;
          scores_d[turn_q] = score_dec;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (timer_q == SHOW_LAST) begin
          timer_d   = '0;
          right_d   = 1'b0;
          wrong_d   = 1'b0;
          timeout_d = 1'b0;
          if (score_cur == WIN) begin
            state_d     = S_OVER;
            game_over_d = 1'b1;
            winner_d    = turn_q;
          end else begin
            turn_d     = next_turn;
            state_d    = S_DEAL;
            deal_req_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_OVER: ;
      default: state_d = S_IDLE;
    endcase

    // Restart overrides whatever the round was doing.
    if (new_game) begin
      state_d     = S_DEAL;
      deal_req_d  = 1'b1;
      timer_d     = '0;
      turn_d      = '0;
      winner_d    = '0;
      scores_d    = '0;
      right_d     = 1'b0;
      wrong_d     = 1'b0;
      timeout_d   = 1'b0;
      game_over_d = 1'b0;
    end
  end

  // NOTE: the score table is a handful of flops, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      turn_q      <= '0;
      winner_q    <= '0;
      scores_q    <= '0;
      card_a_q    <= '0;
      card_b_q    <= '0;
      deal_req_q  <= 1'b0;
      right_q     <= 1'b0;
      wrong_q     <= 1'b0;
      timeout_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q     <= state_d;
      timer_q     <= timer_d;
      turn_q      <= turn_d;
      winner_q    <= winner_d;
      scores_q    <= scores_d;
      card_a_q    <= card_a_d;
      card_b_q    <= card_b_d;
      deal_req_q  <= deal_req_d;
      right_q     <= right_d;
      wrong_q     <= wrong_d;
      timeout_q   <= timeout_d;
      game_over_q <= game_over_d;
    end
  end

  assign deal_req  = deal_req_q;
  assign turn      = turn_q;
  assign right     = right_q;
  assign wrong     = wrong_q;
  assign timeout   = timeout_q;
  assign scores    = scores_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_card_match_judge.sv
// Self-checking bench for card_match_judge: directed rounds plus random rounds
// judged by a score/turn model computed from the game rules.
module tb_card_match_judge;

  localparam int NP   = 3;
  localparam int WINS = 2;
  localparam int TOUT = 8;
  localparam int SHOW = 4;

  logic        clk;
  logic        rst;
  logic        new_game;
  logic [14:0] cards_in;
  logic        cards_valid;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        deal_req;
  logic [1:0]  turn;
  logic        right;
  logic        wrong;
  logic        timeout;
  logic [11:0] scores;
  logic        game_over;
  logic [1:0]  winner;

  int errors;
  int checks;
  int m_score[NP];
  int m_turn;
  bit m_over;
  int junk_codes[3] = '{0, 7, 15};

  card_match_judge #(
    .NUM_PLAYERS(NP), .COLOR_W(2), .NUM_W(3), .SCORE_W(4), .WIN_SCORE(WINS),
    .TIMEOUT(TOUT), .SHOW_CYCLES(SHOW), .PENALTY(1)
  ) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .cards_in(cards_in),
    .cards_valid(cards_valid), .key_code(key_code), .key_valid(key_valid),
    .deal_req(deal_req), .turn(turn), .right(right), .wrong(wrong),
    .timeout(timeout), .scores(scores), .game_over(game_over), .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Card value = colour*8 + number (colour in the upper bits).
  function automatic logic [14:0] pack(int c0, int n0, int c1, int n1, int c2, int n2);
    logic [14:0] v;
    v[4:0]   = 5'(c0 * 8 + n0);
    v[9:5]   = 5'(c1 * 8 + n1);
    v[14:10] = 5'(c2 * 8 + n2);
    return v;
  endfunction

  function automatic int answer(logic [4:0] a, logic [4:0] b);
    int ca, na, cb, nb;
    ca = int'(a) / 8; na = int'(a) % 8;
    cb = int'(b) / 8; nb = int'(b) % 8;
    if (ca == cb && na == nb) return 3;
    if (ca == cb) return 1;
    if (na == nb) return 2;
    return 4;
  endfunction

  function automatic logic [11:0] exp_scores();
    logic [11:0] v;
    for (int p = 0; p < NP; p++) v[p*4 +: 4] = 4'(m_score[p]);
    return v;
  endfunction

  function automatic logic [31:0] all_outputs();
    return 32'({deal_req, turn, right, wrong, timeout, scores, game_over, winner});
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) m_score[p] = 0;
    m_turn = 0;
    m_over = 0;
  endtask

  // Runs one round starting in DEAL; key==0 means let the window expire.
  task automatic play_round(input logic [14:0] cards, input int key, input int delay, input bit junk);
    int nt, exp_code, n_wait;
    logic [2:0] exp_flags;
    check("turn_at_deal", 32'(turn), 32'(m_turn));
    cards_in = cards; cards_valid = 1'b1;
    tick();
    cards_valid = 1'b0;
    check("deal_req_one_shot", 32'(deal_req), 0);
    nt = (m_turn + 1) % NP;
    exp_code = answer(cards[m_turn*5 +: 5], cards[nt*5 +: 5]);
    n_wait = (key == 0) ? TOUT - 1 : delay;
    for (int i = 0; i < n_wait; i++) begin
      if (junk && i < 3) begin
        key_code = 4'(junk_codes[i]); key_valid = 1'b1;
      end
      tick();
      key_valid = 1'b0;
    end
    if (key == 0) begin
      check("no_verdict_before_expiry", 32'({right, wrong, timeout}), 0);
      tick();
      exp_flags = 3'b001;
      if (m_score[m_turn] > 0) m_score[m_turn]--;
    end else begin
      key_code = 4'(key); key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      if (key == exp_code) begin
        exp_flags = 3'b100;
        if (m_score[m_turn] < WINS) m_score[m_turn]++;
      end else begin
        exp_flags = 3'b010;
        if (m_score[m_turn] > 0) m_score[m_turn]--;
      end
    end
    check("verdict", 32'({right, wrong, timeout}), 32'(exp_flags));
    check("scores_after_verdict", 32'(scores), 32'(exp_scores()));
    for (int i = 1; i < SHOW; i++) begin
      tick();
      check("verdict_held", 32'({right, wrong, timeout}), 32'(exp_flags));
    end
    tick();
    check("verdict_cleared", 32'({right, wrong, timeout}), 0);
    if (m_score[m_turn] == WINS) begin
      m_over = 1;
      check("game_over_set", 32'(game_over), 1);
      check("winner", 32'(winner), 32'(m_turn));
      check("no_deal_when_over", 32'(deal_req), 0);
    end else begin
      m_turn = nt;
      check("turn_advanced", 32'(turn), 32'(m_turn));
      check("deal_req_next_round", 32'(deal_req), 1);
      check("game_not_over", 32'(game_over), 0);
    end
  endtask

  task automatic start_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_reset();
    check("new_game_deal_req", 32'(deal_req), 1);
    check("new_game_scores", 32'(scores), 0);
    check("new_game_turn_over_winner", 32'({turn, game_over, winner}), 0);
  endtask

  initial begin
    logic [14:0] rc;
    int sel, rkey, rnt;
    errors = 0; checks = 0;
    rst = 1'b0; new_game = 1'b0; cards_in = '0; cards_valid = 1'b0;
    key_code = '0; key_valid = 1'b0;
    model_reset();

    #12;
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b1;
    tick(); tick();
    check("idle_quiet", all_outputs(), 0);
    start_game();

    play_round(pack(2, 5, 2, 3, 0, 0), 1, 2, 0);   // same colour -> right, P0=1
    play_round(pack(0, 0, 1, 4, 3, 4), 1, 0, 0);   // wrong, P1 floored at 0
    play_round(pack(0, 0, 0, 0, 0, 1), 0, 0, 0);   // timeout, turn wraps
    play_round(pack(3, 1, 2, 2, 0, 0), 1, 7, 0);   // key on expiry cycle, judged wrong
    play_round(pack(0, 0, 1, 4, 3, 4), 2, 0, 0);   // same number -> right, P1=1
    play_round(pack(1, 6, 0, 0, 1, 6), 3, 4, 1);   // junk codes ignored, identical -> right
    play_round(pack(0, 2, 1, 2, 0, 0), 2, 1, 0);   // P0=1
    play_round(pack(0, 0, 2, 7, 2, 1), 4, 3, 0);   // wrong, P1 back to 0
    play_round(pack(0, 0, 0, 0, 0, 0), 0, 0, 1);   // timeout with junk, P2 back to 0
    play_round(pack(3, 3, 0, 0, 0, 0), 4, 5, 0);   // nothing matches -> right, P0 wins

    key_code = 4'd3; key_valid = 1'b1;
    tick();
    key_valid = 1'b0; cards_valid = 1'b1;
    tick();
    cards_valid = 1'b0;
    check("over_scores_hold", 32'(scores), 32'(exp_scores()));
    check("over_flags_hold", 32'({deal_req, right, wrong, timeout, game_over, winner}), 32'b0000100);
    start_game();

    for (int r = 0; r < 60 && !m_over; r++) begin
      rc   = 15'($urandom);
      rnt  = (m_turn + 1) % NP;
      sel  = int'($urandom_range(0, 3));
      rkey = (sel == 0) ? 0 :
             (sel == 1) ? int'($urandom_range(1, 4)) : answer(rc[m_turn*5 +: 5], rc[rnt*5 +: 5]);
      play_round(rc, rkey, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    start_game();
    cards_in = pack(2, 2, 2, 2, 0, 0); cards_valid = 1'b1;
    tick();
    cards_valid = 1'b0; key_code = 4'd3; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("pre_reset_right", 32'({right, scores}), 32'({1'b1, 12'h001}));
    tick();
    #2 rst = 1'b0;
    #1 check("async_reset_mid_show", all_outputs(), 0);
    tick();
    check("reset_held", all_outputs(), 0);
    #3 rst = 1'b1;
    tick();
    check("idle_after_reset", all_outputs(), 0);
    start_game();

    play_round(pack(0, 1, 0, 2, 0, 0), 1, 1, 0);   // P0=1, turn 1
    cards_in = pack(0, 0, 1, 1, 1, 1); cards_valid = 1'b1;
    tick();
    cards_valid = 1'b0;
    tick(); tick();
    start_game();
    check("abort_flags", 32'({right, wrong, timeout}), 0);
    key_code = 4'd1; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("key_ignored_in_deal", 32'({right, wrong, timeout, scores}), 0);
    play_round(pack(1, 3, 2, 3, 0, 0), 2, 0, 0);   // same number -> right after restart

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/card_match_judge.md
Name: card_match_judge

Overview:
- Parametrised successor to the two-player right/wrong checker.
- Runs complete rounds of the card-matching game for NUM_PLAYERS players:
  - requests a deal from the random/card-value path;
  - waits for a keypad answer, with a timeout;
  - judges the answer against the current player's and next player's cards;
  - keeps a saturating score per player, rotates the turn and declares a winner.
- Sits between keypad_scan/card_value and the LED/seven-segment display blocks.

Parameters:
NUM_PLAYERS, 2, number of players (2..8)
COLOR_W, 2, card colour field width
NUM_W, 3, card number field width
SCORE_W, 4, per-player score width
WIN_SCORE, 9, score that ends the game (must be < 2^SCORE_W)
TIMEOUT, 50000000, answer window in clk cycles (>= 2)
SHOW_CYCLES, 25000000, cycles the verdict is held (>= 1)
PENALTY, 1, 1 = wrong answer or timeout decrements score (floor 0), 0 = no penalty
TW (derived), max(1, ceil(log2(NUM_PLAYERS))), turn/winner index width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
new_game  input  1  one-cycle pulse: clear scores, restart play
cards_in  input  NUM_PLAYERS*(COLOR_W+NUM_W)  packed cards; player p at [p*CW +: CW], CW=COLOR_W+NUM_W, colour in upper COLOR_W bits
cards_valid  input  1  one-cycle pulse: cards_in holds a fresh deal
key_code  input  4  keypad code: 1 = same colour, 2 = same number, 3 = identical, 4 = nothing matches
key_valid  input  1  one-cycle pulse: key_code valid
deal_req  output  1  one-cycle pulse requesting a new deal (drives random enable)
turn  output  TW  index of the answering player
right  output  1  verdict: correct
wrong  output  1  verdict: incorrect answer
timeout  output  1  verdict: no answer in window
scores  output  NUM_PLAYERS*SCORE_W  packed scores; player p at [p*SCORE_W +: SCORE_W]
game_over  output  1  game finished
winner  output  TW  winning player index, valid when game_over=1

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; scores 0; turn 0; timer 0; latched cards 0.
- All outputs are registered.

FSM states: IDLE, DEAL, WAIT_KEY, SHOW, OVER.
- IDLE: waits for new_game.
- DEAL:
  - deal_req=1 exactly on the first cycle in DEAL.
  - Waits for cards_valid, then latches the current player's card A=turn and the next player's card B=(turn+1) mod NUM_PLAYERS.
  - Then goes to WAIT_KEY with the timer cleared.
  - cards_valid on the same cycle as deal_req is accepted.
- WAIT_KEY:
  - Timer increments each cycle.
  - key_valid with code 1..4: on the next edge, go to SHOW with right or wrong set and the score updated.
  - key_valid with any other code (0, 5..15) is ignored and the timer keeps running.
  - Timer reaching TIMEOUT-1 with no valid key: go to SHOW with timeout=1.
  - A valid key on the same cycle as expiry wins; it is judged, not timed out.
- Correct answer, from the latched cards:
  - code 3 if colours and numbers are both equal;
  - else 1 if only the colours are equal;
  - else 2 if only the numbers are equal;
  - else 4.
- Scoring:
  - Correct: score[turn] += 1, saturating at WIN_SCORE.
  - Wrong or timeout with PENALTY=1: score[turn] -= 1, floored at 0.
  - Wrong or timeout with PENALTY=0: no change.
- SHOW:
  - Exactly one of right/wrong/timeout is held high for SHOW_CYCLES cycles, then all three clear.
  - Then, if score[turn]==WIN_SCORE: go to OVER with winner=turn and game_over=1.
  - Otherwise turn = (turn+1) mod NUM_PLAYERS (wraps to 0 after NUM_PLAYERS-1) and go to DEAL.
- OVER: holds scores, winner and game_over until new_game or reset.
- new_game in any state, including mid-round:
  - on the next edge, scores=0, turn=0, verdict flags=0, game_over=0, winner=0;
  - state goes to DEAL.
- key_valid outside WAIT_KEY and cards_valid outside DEAL are ignored.
- Latency:
  - key_valid to verdict/score visible: 1 cycle.
  - new_game to deal_req: 1 cycle.

Test Plan:
Settings for all directed tests: NUM_PLAYERS=3, WIN_SCORE=2, TIMEOUT=8, SHOW_CYCLES=4, PENALTY=1.
1. Reset, new_game, cards_valid with P0=(c2,n5), P1=(c2,n3), key 1 -> next cycle right=1 for 4 cycles; scores[P0]=1; turn becomes 1; deal_req pulses.
2. P1=(c1,n4), P2=(c3,n4), key 1 -> wrong=1; scores[P1] stays 0 (floor). Repeat with key 2 -> right, scores[P1]=1.
3. Turn 2, no key for 8 cycles -> timeout=1; scores[P2] unchanged at 0; turn wraps to 0. Key on the expiry cycle -> judged, not timeout.
4. Key codes 0, 7, 15 in WAIT_KEY -> ignored; the later key 3 with identical cards -> right.
5. P0 reaches 2 -> after SHOW, game_over=1, winner=0; further keys and cards_valid ignored; new_game -> scores 0, deal_req 1 cycle later.
6. Assert rst low mid-SHOW -> all outputs 0 immediately; new_game in WAIT_KEY aborts the round (no score change, turn=0).
